// File: rtl/bcd_autoscale.sv
// bcd_autoscale
// Sequential binary-to-BCD converter with automatic decimal-point placement.
// The input is a frequency in milli-hertz, so the value has three implied
// fraction digits. The block converts it with double-dabble into seven BCD
// digits (d6..d3 integer part, d2..d0 fraction). It then slides the value left
// one digit at a time until the leftmost displayed digit is non-zero, or until
// three fraction digits are showing. The four displayed digits are truncated,
// never rounded.
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high reset
//   start     one-cycle request, accepted only while ready is high
//   bin       unsigned value in mHz, sampled on the edge that accepts start
//   ready     high while idle
//   done_tick one-cycle pulse; result outputs are updated in this cycle
//   bcd3..0   displayed digits, bcd3 leftmost
//   dp_pos    number of digits right of the decimal point (0..3)

module bcd_autoscale #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         ready,
  output logic         done_tick,
  output logic [3:0]   bcd3,
  output logic [3:0]   bcd2,
  output logic [3:0]   bcd1,
  output logic [3:0]   bcd0,
  output logic [1:0]   dp_pos
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    NORM,
    DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_bin;
  logic [27:0]    r_bcd;
  logic [27:0]    w_adj;
  logic [CW-1:0]  r_cnt;
  logic [1:0]     r_dp;
  logic [15:0]    r_bcdOut;
  logic [1:0]     r_dpOut;
  logic           r_done;
  logic           w_load;
  logic           w_conv;
  logic           w_shiftDigit;
  logic           w_latch;

  // Double-dabble correction: any digit of 5 or more gets 3 added so that
  // the following left shift carries correctly into the next decade.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 7; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and datapath control strobes. The conversion ends when
  // the counter is at 1, because that cycle performs the W-th shift.
  // Normalisation stops once the leftmost digit is non-zero or three
  // fraction digits are visible; zero therefore ends up as 0.000.
  always_comb begin
    w_next       = r_state;
    w_load       = 1'b0;
    w_conv       = 1'b0;
    w_shiftDigit = 1'b0;
    w_latch      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = CONV;
        end
      end
      CONV: begin
        w_conv = 1'b1;
        if (r_cnt == CW'(1)) begin
          w_next = NORM;
        end
      end
      NORM: begin
        if ((r_bcd[27:24] == 4'd0) && (r_dp != 2'd3)) begin
          w_shiftDigit = 1'b1;
        end else begin
          w_latch = 1'b1;
          w_next  = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Conversion datapath: shift register, BCD digits, counter and dp.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_dp  <= 2'd0;
    end else if (w_load) begin
      r_bin <= bin;
      r_bcd <= '0;
      r_cnt <= CW'(W);
      r_dp  <= 2'd0;
    end else if (w_conv) begin
      r_bcd <= {w_adj[26:0], r_bin[W-1]};
      r_bin <= {r_bin[W-2:0], 1'b0};
      r_cnt <= r_cnt - CW'(1);
    end else if (w_shiftDigit) begin
      r_bcd <= {r_bcd[23:0], 4'd0};
      r_dp  <= r_dp + 2'd1;
    end
  end

  // Result registers hold the last result until the next one is latched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bcdOut <= '0;
      r_dpOut  <= 2'd0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_latch;
      if (w_latch) begin
        r_bcdOut <= r_bcd[27:12];
        r_dpOut  <= r_dp;
      end
    end
  end

  assign ready     = (r_state == IDLE);
  assign done_tick = r_done;
  assign bcd3      = r_bcdOut[15:12];
  assign bcd2      = r_bcdOut[11:8];
  assign bcd1      = r_bcdOut[7:4];
  assign bcd0      = r_bcdOut[3:0];
  assign dp_pos    = r_dpOut;

endmodule

// File: tb/tb_bcd_autoscale.sv
// tb_bcd_autoscale
// Directed-vector bench for bcd_autoscale with W=20. Each vector gives the
// input in mHz, the hand-computed displayed digits, the decimal-point
// position and the number of normalising shifts. The done_tick timing is
// checked to the exact edge.

module tb_bcd_autoscale;

  localparam int W = 20;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] bin;
  logic         ready;
  logic         done_tick;
  logic [3:0]   bcd3;
  logic [3:0]   bcd2;
  logic [3:0]   bcd1;
  logic [3:0]   bcd0;
  logic [1:0]   dp_pos;

  int vectorCount = 0;
  int missCount   = 0;

  bcd_autoscale #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bin       (bin),
    .ready     (ready),
    .done_tick (done_tick),
    .bcd3      (bcd3),
    .bcd2      (bcd2),
    .bcd1      (bcd1),
    .bcd0      (bcd0),
    .dp_pos    (dp_pos)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Presents start with a value, lets the next edge accept it and returns
  // #1 after that edge. bin is scrambled afterwards so that a late sample
  // would show up as a wrong result.
  task automatic applyStimulus(input logic [W-1:0] value);
    @(negedge clk);
    start = 1'b1;
    bin   = value;
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = ~value;
  endtask

  // Steps edge by edge until done_tick is seen. edges returns the number of
  // the edge after which done_tick went high, counted from the accept edge.
  task automatic waitDone(input int firstEdge, output int edges);
    edges = firstEdge;
    while (!done_tick && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!done_tick) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
    end
  endtask

  // Runs one conversion and checks timing, result and the return to idle.
  task automatic runVector(input string tag, input logic [W-1:0] value,
                           input logic [15:0] expBcd, input logic [1:0] expDp,
                           input int expN);
    int edges;
    applyStimulus(value);
    checkOutput({tag, "_busy"}, {31'd0, ready}, 32'd0);
    waitDone(0, edges);
    checkOutput({tag, "_latency"}, edges, W + 1 + expN);
    checkOutput({tag, "_bcd"}, {16'd0, bcd3, bcd2, bcd1, bcd0}, {16'd0, expBcd});
    checkOutput({tag, "_dp"}, {30'd0, dp_pos}, {30'd0, expDp});
    @(posedge clk);
    #1;
    checkOutput({tag, "_doneLow"}, {31'd0, done_tick}, 32'd0);
    checkOutput({tag, "_readyBack"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin : stimulus
    int edges;
    int doneSeen;

    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    #1;
    checkOutput("reset_ready", {31'd0, ready}, 32'd1);
    checkOutput("reset_done", {31'd0, done_tick}, 32'd0);
    checkOutput("reset_bcd", {16'd0, bcd3, bcd2, bcd1, bcd0}, 32'd0);
    checkOutput("reset_dp", {30'd0, dp_pos}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Main conversions: value, digits, dp position, normalising shifts.
    runVector("v1316",    20'd1316,    16'h1316, 2'd3, 3);
    runVector("v16666",   20'd16666,   16'h1666, 2'd2, 2);
    runVector("v1000000", 20'd1000000, 16'h1000, 2'd0, 0);
    runVector("v1048575", 20'd1048575, 16'h1048, 2'd0, 0);
    runVector("v0",       20'd0,       16'h0000, 2'd3, 3);
    runVector("v333333",  20'd333333,  16'h3333, 2'd1, 1);

    // Outputs hold the previous result while idle and during conversion.
    repeat (4) @(posedge clk);
    #1;
    checkOutput("hold_idle", {16'd0, bcd3, bcd2, bcd1, bcd0}, 32'h3333);

    // A second start in the middle of CONV must be ignored.
    applyStimulus(20'd1316);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    checkOutput("hold_conv", {16'd0, bcd3, bcd2, bcd1, bcd0}, 32'h3333);
    start = 1'b1;
    bin   = 20'd99999;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(6, edges);
    checkOutput("restart_latency", edges, W + 1 + 3);
    checkOutput("restart_bcd", {16'd0, bcd3, bcd2, bcd1, bcd0}, 32'h1316);
    checkOutput("restart_dp", {30'd0, dp_pos}, 32'd3);
    doneSeen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done_tick) doneSeen++;
    end
    checkOutput("restart_singleDone", doneSeen, 0);

    // Reset during NORM: abort asynchronously, no done_tick afterwards.
    applyStimulus(20'd16666);
    repeat (W + 1) begin
      @(posedge clk);
      #1;
    end
    checkOutput("norm_busy", {31'd0, ready}, 32'd0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("abort_ready", {31'd0, ready}, 32'd1);
    checkOutput("abort_bcd", {16'd0, bcd3, bcd2, bcd1, bcd0}, 32'd0);
    checkOutput("abort_dp", {30'd0, dp_pos}, 32'd0);
    checkOutput("abort_done", {31'd0, done_tick}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    doneSeen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done_tick) doneSeen++;
    end
    checkOutput("abort_noDone", doneSeen, 0);

    runVector("v5882", 20'd5882, 16'h5882, 2'd3, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/bcd_autoscale.md
Name: bcd_autoscale

Overview:
Sequential binary-to-BCD converter with automatic decimal-point placement. It sits between the frequency-counter arithmetic and the 4-digit seven-segment display mux. The input is a frequency in milli-hertz, i.e. a fixed-point value with three implied decimal fraction digits. The block outputs the four most significant displayable BCD digits and a 2-bit decimal-point position, in the same encoding the display stage already decodes to drive its dp inputs.

Parameters:
W, 20, width of the binary input; legal range 4..23, so the value always fits in 7 BCD digits.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request; accepted only while ready=1
bin  input  W  unsigned value in mHz; sampled on the edge that accepts start
ready  output  1  high in IDLE only
done_tick  output  1  one-cycle pulse; result outputs are valid and updated in this cycle
bcd3  output  4  leftmost displayed digit
bcd2  output  4  second displayed digit
bcd1  output  4  third displayed digit
bcd0  output  4  rightmost displayed digit
dp_pos  output  2  digits right of the decimal point (0 = integer, 3 = x.xxx)

Behaviour:
- Reset (async): state=IDLE, ready=1, done_tick=0, bcd3..bcd0=0, dp_pos=0, internal registers cleared.
- States: IDLE, CONV, NORM, DONE.
- IDLE: on start=1, load the shift register from bin, clear the 7-digit BCD register d6..d0, set the iteration counter to W and dp=0, then go to CONV. With start=0, stay in IDLE.
- CONV (exactly W cycles): double-dabble. Each cycle:
  - add 3 to every digit >= 5;
  - shift {d6..d0, bin_reg} left one bit, bringing in the bin MSB;
  - decrement the counter.
  - After the W-th shift, go to NORM. Result: d6..d3 hold the integer part and d2..d0 the fraction.
- NORM: the window is d6..d3. Each cycle:
  - if d6==0 and dp<3: shift the BCD register left one digit (d0 <= 0) and increment dp;
  - otherwise: load bcd3..bcd0 <= d6..d3 and dp_pos <= dp, then go to DONE.
  - Lower digits are truncated, never rounded.
- DONE: done_tick=1 for exactly one cycle, then go to IDLE.
- Latency: with start accepted at edge 0 and n normalising shifts (0..3), done_tick is high in the cycle after edge W+1+n. ready returns high after edge W+2+n.
- start while ready=0 is ignored; there is no queueing.
- bin changes after acceptance have no effect.
- Result outputs hold their last value until the next DONE.
- Zero input normalises to 0.000 (dp_pos=3).
- Reset asserted mid-operation aborts immediately to the reset values; no done_tick is produced.
- done_tick and the outputs are registered, with no combinational path from inputs.

Test Plan:
- W=20, bin=1316 -> after 20+1+3 edges: done_tick one cycle, bcd=1,3,1,6, dp_pos=3 (1.316 Hz).
- bin=16666 -> bcd=1,6,6,6, dp_pos=2, n=2; check done_tick timing to the exact cycle.
- bin=1000000 -> bcd=1,0,0,0, dp_pos=0, n=0; bin=1048575 -> bcd=1,0,4,8, dp_pos=0 (truncation, no rounding).
- bin=0 -> bcd=0,0,0,0, dp_pos=3; bin=333333 -> bcd=3,3,3,3, dp_pos=1.
- Pulse start again mid-CONV with a different bin -> ignored; result matches the first bin, single done_tick.
- Assert reset during NORM -> all outputs 0 and ready=1 asynchronously; no done_tick; a following start with bin=5882 -> bcd=5,8,8,2, dp_pos=3.
